clip_pipe: RTL and testbench

// - Multi-channel, pipelined audio output limiter between the mix/effects accumulators and the DAC/I2S path.
// - Per-sample runtime gain: arithmetic right shift.
// - Selectable limiting mode: hard saturate, soft knee, or wrap.
// - Clip reporting: per-sample flags, per-channel held clip indicators for the UI, and a saturating clip-event counter.

---
 rtl/clip_pkg.sv | 28 ++
 rtl/clip_lane.sv | 49 ++++
 rtl/clip_pipe.sv | 165 ++++++++++++++++
 tb/tb_clip_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clip_pkg.sv
// Shared types and helpers for the audio output limiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package clip_pkg;

  typedef enum logic [1:0] {
    CLIP_HARD = 2'd0,
    CLIP_SOFT = 2'd1,
    CLIP_WRAP = 2'd2,
    CLIP_RSVD = 2'd3
  } clip_mode_t;

  // Clamp a signed value into the range of a signed integer of 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/clip_lane.sv
// One lane of the output limiter: shifted sample plus mode -> narrow sample and clip flag.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module clip_lane
  import clip_pkg::*;
#(
  parameter int WIDTH_FULL = 24,
  parameter int WIDTH_CLIP = 16
) (
  input  logic signed [WIDTH_FULL-1:0] x_i,
  input  clip_mode_t                   mode_i,
  output logic signed [WIDTH_CLIP-1:0] y_o,
  output logic                         flag_o
);

  // One extra bit so the soft-knee sum can never overflow before clamping.
  localparam int KW = WIDTH_FULL + 1;
  localparam logic signed [KW-1:0] KNEE = KW'(1) <<< (WIDTH_CLIP - 2);

  logic signed [KW-1:0]         xe;
  logic signed [KW-1:0]         k;
  logic signed [63:0]           k64;
  logic signed [63:0]           s64;
  logic        [WIDTH_FULL-1:0] wrap_ext;

  // Knee shaping, then a common clamp; wrap mode bypasses the clamp entirely.
  always_comb begin
    xe       = KW'(x_i);
    k        = xe;
    wrap_ext = {{(WIDTH_FULL - WIDTH_CLIP){x_i[WIDTH_CLIP-1]}}, x_i[WIDTH_CLIP-1:0]};
    if (mode_i == CLIP_SOFT) begin
      if (xe > KNEE) begin
        k = KNEE + ((xe - KNEE) >>> 2);
      end else if (xe < -KNEE) begin
        k = -KNEE + ((xe + KNEE) >>> 2);
      end
    end
    k64 = 64'(k);
    s64 = sat_signed(k64, WIDTH_CLIP);
    if (mode_i == CLIP_WRAP) begin
      y_o    = x_i[WIDTH_CLIP-1:0];
      flag_o = (wrap_ext != $unsigned(x_i));
    end else begin
      y_o    = s64[WIDTH_CLIP-1:0];
      flag_o = (s64 != k64);
    end
  end

endmodule

// File: rtl/clip_pipe.sv
// Multi-channel audio output limiter: runtime shift, hard/soft/wrap limiting, clip reporting.
// Latency: 2 cycles from input accept to dout_valid_o; one vector per cycle sustained.
// Backpressure: valid/ready both sides; din_ready_o is the only combinational path (from dout_ready_i).
module clip_pipe
  import clip_pkg::*;
#(
  parameter  int WIDTH_FULL  = 24,
  parameter  int WIDTH_CLIP  = 16,
  parameter  int NUM_CH      = 2,
  parameter  int MAX_SHIFT   = 15,
  parameter  int HOLD_CYCLES = 4,
  parameter  int CNT_W       = 16,
  localparam int SHW         = $clog2(MAX_SHIFT + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  clip_mode_t                   mode_i,
  input  logic [SHW-1:0]               shift_i,
  input  logic                         din_valid_i,
  output logic                         din_ready_o,
  input  logic [NUM_CH*WIDTH_FULL-1:0] din_i,
  output logic                         dout_valid_o,
  input  logic                         dout_ready_i,
  output logic [NUM_CH*WIDTH_CLIP-1:0] dout_o,
  output logic [NUM_CH-1:0]            clip_flag_o,
  output logic [NUM_CH-1:0]            clip_hold_o,
  output logic [CNT_W-1:0]             clip_count_o,
  input  logic                         clip_count_clr_i
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  logic                                  v1_q;
  logic                                  v2_q;
  clip_mode_t                            mode1_q;
  logic [NUM_CH-1:0][WIDTH_FULL-1:0]     x1_q;
  logic [NUM_CH-1:0][WIDTH_FULL-1:0]     x1_d;
  logic [SHW-1:0]                        sh_eff;
  logic [WIDTH_CLIP-1:0]                 y2_d    [NUM_CH];
  logic                                  flag2_d [NUM_CH];
  logic [NUM_CH-1:0][WIDTH_CLIP-1:0]     dout_q;
  logic [NUM_CH-1:0]                     flag_q;
  logic [NUM_CH-1:0][HCW-1:0]            hcnt_q;
  logic [NUM_CH-1:0][HCW-1:0]            hcnt_d;
  logic [NUM_CH-1:0]                     hold_q;
  logic [NUM_CH-1:0]                     hold_d;
  logic [CNT_W-1:0]                      cnt_q;
  logic [CNT_W-1:0]                      cnt_d;
  logic                                  s1_load;
  logic                                  s2_load;
  logic                                  accept;
  logic                                  out_xfer;

  // Stage advance conditions; a stage may load whenever the stage after it drains.
  always_comb begin
    s2_load  = !v2_q || dout_ready_i;
    s1_load  = !v1_q || s2_load;
    accept   = din_valid_i && s1_load;
    out_xfer = v2_q && dout_ready_i;
  end

  assign din_ready_o  = s1_load;
  assign dout_valid_o = v2_q;
  assign dout_o       = dout_q;
  assign clip_flag_o  = flag_q;
  assign clip_hold_o  = hold_q;
  assign clip_count_o = cnt_q;

  // Stage-1 datapath: clamp the shift amount and arithmetic-shift every lane.
  always_comb begin
    sh_eff = (int'(shift_i) > MAX_SHIFT) ? SHW'(MAX_SHIFT) : shift_i;
    for (int i = 0; i < NUM_CH; i++) begin
      x1_d[i] = $signed(din_i[i*WIDTH_FULL +: WIDTH_FULL]) >>> sh_eff;
    end
  end

  // Stage-2 datapath: one limiter lane per channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    clip_lane #(
      .WIDTH_FULL (WIDTH_FULL),
      .WIDTH_CLIP (WIDTH_CLIP)
    ) u_lane (
      .x_i    ($signed(x1_q[g])),
      .mode_i (mode1_q),
      .y_o    (y2_d[g]),
      .flag_o (flag2_d[g])
    );
  end

  // Stage-1 register: shifted samples and the mode that travels with them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      mode1_q <= CLIP_HARD;
      x1_q    <= '0;
    end else if (s1_load) begin
      v1_q <= din_valid_i;
      if (accept) begin
        mode1_q <= mode_i;
        x1_q    <= x1_d;
      end
    end
  end

  // Stage-2 register: output samples and flags, frozen while downstream stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v2_q   <= 1'b0;
      dout_q <= '0;
      flag_q <= '0;
    end else if (s2_load) begin
      v2_q <= v1_q;
      if (v1_q) begin
        for (int i = 0; i < NUM_CH; i++) begin
          dout_q[i] <= y2_d[i];
          flag_q[i] <= flag2_d[i];
        end
      end
    end
  end

  // Per-lane hold timers: reload on a clipped output transfer, otherwise run down to zero.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hcnt_d[i] = hcnt_q[i];
      if (out_xfer && flag_q[i]) begin
        hcnt_d[i] = HCW'(HOLD_CYCLES);
      end else if (hcnt_q[i] != '0) begin
        hcnt_d[i] = hcnt_q[i] - HCW'(1);
      end
      hold_d[i] = (hcnt_d[i] != '0);
    end
  end

  // Hold timers and their registered indicator bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      hold_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
    end
  end

  // Clip-event counter: one count per clipped vector, saturating, clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (clip_count_clr_i) begin
      cnt_d = '0;
    end else if (out_xfer && (|flag_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Clip-event counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_clip_pipe.sv
// Self-checking bench for clip_pipe: scoreboard against a plain-arithmetic model.
// Latency: n/a.
// Backpressure: exercised with directed stalls and random dout_ready.
module tb_clip_pipe;
  import clip_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  clip_mode_t  mode = CLIP_HARD;
  logic [3:0]  shift = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [47:0] din = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [31:0] dout;
  logic [1:0]  clip_flag;
  logic [1:0]  clip_hold;
  logic [15:0] clip_count;
  logic        clr = 1'b0;

  logic        din_ready2;
  logic        dout_valid2;
  logic [31:0] dout2;
  logic [1:0]  clip_flag2;
  logic [1:0]  clip_hold2;
  logic [1:0]  clip_count2;

  int n_pass  = 0;
  int n_total = 0;
  int n_out   = 0;
  bit rnd_on  = 0;

  typedef struct packed {
    logic [1:0][15:0] y;
    logic [1:0]       f;
  } exp_t;
  exp_t q[$];

  event sent3;

  always #5 clk = ~clk;

  clip_pipe u_dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .shift_i(shift),
    .din_valid_i(din_valid), .din_ready_o(din_ready), .din_i(din),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .dout_o(dout),
    .clip_flag_o(clip_flag), .clip_hold_o(clip_hold), .clip_count_o(clip_count),
    .clip_count_clr_i(clr)
  );

  clip_pipe #(.CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .shift_i(shift),
    .din_valid_i(din_valid), .din_ready_o(din_ready2), .din_i(din),
    .dout_valid_o(dout_valid2), .dout_ready_i(dout_ready), .dout_o(dout2),
    .clip_flag_o(clip_flag2), .clip_hold_o(clip_hold2), .clip_count_o(clip_count2),
    .clip_count_clr_i(clr)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, exp_v);
  endtask

  // Reference: shift, then the limiting rule for the mode, in plain integer arithmetic.
  function automatic void model(input int x, input int sh, input int md,
                                output int y, output bit f);
    int xs;
    int k;
    xs = x >>> ((sh > 15) ? 15 : sh);
    k  = xs;
    if (md == 2) begin
      y = xs & 32'hFFFF;
      if (y >= 32768) y = y - 65536;
      f = (y != xs);
    end else begin
      if (md == 1) begin
        if (xs > 16384) k = 16384 + (xs - 16384) / 4;
        else if (xs < -16384) k = -16384 - ((-16384 - xs + 3) / 4);
      end
      if (k > 32767) begin y = 32767; f = 1; end
      else if (k < -32768) begin y = -32768; f = 1; end
      else begin y = k; f = 0; end
    end
  endfunction

  // Input capture: every accepted vector pushes its expected output.
  always @(negedge clk) begin : cap
    exp_t e;
    int   yv;
    bit   fv;
    if (!rst && din_valid && din_ready) begin
      for (int c = 0; c < 2; c++) begin
        model(int'($signed(din[c*24 +: 24])), int'(shift), int'(mode), yv, fv);
        e.y[c] = yv[15:0];
        e.f[c] = fv;
      end
      q.push_back(e);
    end
  end

  // Output monitor: pop and compare on each transfer; check stability across stalls.
  always @(negedge clk) begin : mon
    exp_t        e;
    bit          stall_q;
    logic [31:0] st_dout;
    logic [1:0]  st_flag;
    if (rst) begin
      stall_q = 0;
    end else begin
      if (stall_q && dout_valid) begin
        chk("stall_dout", int'(dout), int'(st_dout));
        chk("stall_flag", int'(clip_flag), int'(st_flag));
      end
      if (dout_valid && dout_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: actual %h required none", dout);
        end else begin
          e = q.pop_front();
          for (int c = 0; c < 2; c++) begin
            chk($sformatf("dout_ch%0d", c), int'($signed(dout[c*16 +: 16])), int'($signed(e.y[c])));
            chk($sformatf("flag_ch%0d", c), int'(clip_flag[c]), int'(e.f[c]));
          end
        end
      end
      stall_q = dout_valid && !dout_ready;
      st_dout = dout;
      st_flag = clip_flag;
    end
  end

  // Present one vector and hold it until accepted; returns 1ns after the accept edge.
  task automatic send(input int md, input int sh, input int a, input int b);
    bit acc;
    int t;
    mode      = clip_mode_t'(md[1:0]);
    shift     = sh[3:0];
    din       = {b[23:0], a[23:0]};
    din_valid = 1'b1;
    acc = 0;
    t   = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: actual not_accepted required accepted");
    end
  endtask

  task automatic check_vec(input string nm, input int y0, input int f0, input int y1, input int f1);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!dout_valid && t < 20);
    if (!dout_valid) begin
      n_total++;
      $display("FAIL %s_timeout: actual no_output required output", nm);
    end else begin
      chk({nm, "_y0"}, int'($signed(dout[15:0])), y0);
      chk({nm, "_f0"}, int'(clip_flag[0]), f0);
      chk({nm, "_y1"}, int'($signed(dout[31:16])), y1);
      chk({nm, "_f1"}, int'(clip_flag[1]), f1);
    end
  endtask

  task automatic directed(input string nm, input int md, input int sh, input int a, input int b,
                          input int y0, input int f0, input int y1, input int f1);
    send(md, sh, a, b);
    din_valid = 1'b0;
    check_vec(nm, y0, f0, y1, f1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q.size() != 0 || dout_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, q.size(), 0);
  endtask

  initial begin
    int n0;
    int h0;
    int h1;
    int lat;
    int a;
    int b;
    int sh;

    // Reset values while reset is held.
    @(negedge clk);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_din_ready", int'(din_ready), 1);
    chk("rst_dout", int'(dout), 0);
    chk("rst_clip_flag", int'(clip_flag), 0);
    chk("rst_clip_hold", int'(clip_hold), 0);
    chk("rst_clip_count", int'(clip_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed arithmetic vectors.
    directed("hard_s8", 0, 8, 'h7F0000, 'hFFF000, 32512, 0, -16, 0);
    directed("hard_s4", 0, 4, 'h100000, 'hF80000, 32767, 1, -32768, 0);
    directed("hard_negfs", 0, 0, 'h800000, 'h007FFF, -32768, 1, 32767, 0);
    directed("hard_s15", 0, 15, 'h7FFFFF, 'h800000, 255, 0, -256, 0);
    directed("soft_a", 1, 0, 20000, -20000, 17288, 0, -17288, 0);
    directed("soft_b", 1, 0, 200000, 10000, 32767, 1, 10000, 0);
    directed("wrap", 2, 0, 40000, -32768, -25536, 1, -32768, 0);
    directed("rsvd", 3, 0, 40000, -40000, 32767, 1, -32768, 1);

    // Stream 1..8 with a 3-cycle stall once sample 3 reaches the output.
    n0 = n_out;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          send(0, 0, i, 100 + i);
          if (i == 3) ->sent3;
        end
        din_valid = 1'b0;
      end
      begin
        @(sent3);
        @(posedge clk);
        #1 dout_ready = 1'b0;
        @(negedge clk);
        chk("bp_din_ready_low", int'(din_ready), 0);
        chk("bp_stalled_sample", int'($signed(dout[15:0])), 3);
        repeat (3) @(posedge clk);
        #1 dout_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", n_out - n0, 8);

    // Hold timer and count for a single clip on ch1.
    repeat (10) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    send(0, 4, 'h100, 'h100000);
    din_valid = 1'b0;
    h0 = 0;
    h1 = 0;
    repeat (16) begin
      @(negedge clk);
      h0 += int'(clip_hold[0]);
      h1 += int'(clip_hold[1]);
    end
    chk("hold_ch1_cycles", h1, 4);
    chk("hold_ch0_cycles", h0, 0);
    chk("count_one", int'(clip_count), 1);

    // Clear on the same cycle as a clipped transfer.
    @(posedge clk);
    #1;
    send(0, 0, 'h7FFFFF, 0);
    din_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dout_valid && lat < 20);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("count_clr_wins", int'(clip_count), 0);
    chk("count2_clr_wins", int'(clip_count2), 0);

    // Saturation of the narrow counter.
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(0, 0, 'h400000, 'hC00000);
    din_valid = 1'b0;
    drain("sat_drain");
    chk("count_five", int'(clip_count), 5);
    chk("count2_saturated", int'(clip_count2), 3);

    // Asynchronous reset with both stages full.
    @(posedge clk);
    #1 dout_ready = 1'b0;
    send(0, 0, 11, 12);
    send(0, 0, 13, 14);
    din_valid = 1'b0;
    @(negedge clk);
    chk("full_dout_valid", int'(dout_valid), 1);
    chk("full_din_ready", int'(din_ready), 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_dout_valid", int'(dout_valid), 0);
    chk("arst_din_ready", int'(din_ready), 1);
    q.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1 dout_ready = 1'b1;
    send(0, 0, 21, 22);
    din_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dout_valid && lat < 20);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_value", int'($signed(dout[15:0])), 21);
    drain("rst_drain");

    // Random traffic with random backpressure.
    @(posedge clk);
    #1 rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            din_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          a  = ($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 140000)) - 70000;
          b  = ($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 140000)) - 70000;
          sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
          send(int'($urandom_range(0, 3)), sh, a, b);
        end
        din_valid = 1'b0;
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 dout_ready = ($urandom_range(0, 2) != 0);
        end
        dout_ready = 1'b1;
      end
    join
    dout_ready = 1'b1;
    drain("rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
